wbc_kw11l: RTL

KW11-L compatible line time clock controller. It sits between the reset/timer generator's 50 Hz system tick and the CPU.
- Edge-detects the tick and sets the monitor bit.
- Raises a vectored interrupt when enabled and runs the irq/iack handshake with the interrupt arbiter.
- Exposes the CSR (bus address 177546) as a Wishbone slave.

---
 rtl/kw11l_pkg.sv | 27 ++
 rtl/wbc_tick_det.sv | 23 ++
 rtl/wbc_kw11l.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/kw11l_pkg.sv
// Shared definitions for the KW11-L line time clock: CSR bit positions,
// register offsets, default vector and the interrupt handshake states.
package kw11l_pkg;

  localparam int CSR_MON_BIT = 7;
  localparam int CSR_IE_BIT  = 6;

  localparam logic [8:0] KW11L_VECTOR_DEFAULT = 9'o100;

  localparam logic ADR_CSR     = 1'b0;
  localparam logic ADR_TICKCNT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } irq_state_t;

  function automatic logic [15:0] csr_word(input logic mon, input logic ie);
    logic [15:0] w;
    w              = 16'h0000;
    w[CSR_MON_BIT] = mon;
    w[CSR_IE_BIT]  = ie;
    return w;
  endfunction

endpackage

// File: rtl/wbc_tick_det.sv
// Rising-edge detector for a same-domain level tick, gated by an enable.
// Emits exactly one tick_ev cycle per rising edge of i_tick while enabled.
module wbc_tick_det (
  input  logic clk,
  input  logic srst,
  input  logic i_tick,
  input  logic i_ena,
  output logic o_tick_ev
);

  logic r_tick_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_tick_q <= 1'b0;
    end else begin
      r_tick_q <= i_tick;
    end
  end

  assign o_tick_ev = i_tick & ~r_tick_q & i_ena;

endmodule

// File: rtl/wbc_kw11l.sv
// KW11-L line time clock with Wishbone CSR and vectored irq/iack handshake.
// Define KW11L_TICKCNT_EN to add a 16-bit tick counter at word address 1.
module wbc_kw11l
  import kw11l_pkg::*;
#(
  parameter logic [8:0] VECTOR      = KW11L_VECTOR_DEFAULT,
  parameter logic       ENA_DEFAULT = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  output logic        wb_ack_o,
  input  logic        tick_i,
  input  logic        ena_i,
  output logic        irq_o,
  output logic [8:0]  ivec_o,
  input  logic        iack_i
);

  logic       r_ack;
  logic [15:0] r_dat;
  logic       r_mon;
  logic       r_ie;
  irq_state_t r_state;
  irq_state_t w_state_next;
  logic       w_irq;
  logic       w_tick_ev;
  logic       w_acc;
  logic       w_wr;
  logic       w_csr_sel;
  logic       w_csr_wr;
  logic [15:0] w_rd_data;

  wbc_tick_det u_tick_det (
    .clk       (wb_clk_i),
    .srst      (wb_rst_i),
    .i_tick    (tick_i),
    .i_ena     (ena_i & ENA_DEFAULT),
    .o_tick_ev (w_tick_ev)
  );

  // The access edge is the one at which ack rises; writes commit there.
  assign w_acc    = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr     = w_acc & wb_we_i;
  assign w_csr_wr = w_wr & w_csr_sel & wb_sel_i[0];

`ifdef KW11L_TICKCNT_EN
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic [15:0] w_cnt_inc;
  logic        w_cnt_wr;

  assign w_csr_sel = (wb_adr_i == ADR_CSR);
  assign w_cnt_wr  = w_wr & (wb_adr_i == ADR_TICKCNT) & (|wb_sel_i);
  assign w_cnt_inc = r_cnt + 16'd1;

  // A bus write suppresses that cycle's increment, even on an unwritten lane.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt_lane
    assign w_cnt_next[gi*8 +: 8] =
      w_cnt_wr  ? (wb_sel_i[gi] ? wb_dat_i[gi*8 +: 8] : r_cnt[gi*8 +: 8]) :
      w_tick_ev ? w_cnt_inc[gi*8 +: 8] : r_cnt[gi*8 +: 8];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cnt <= 16'h0000;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign w_rd_data = (wb_adr_i == ADR_TICKCNT) ? r_cnt : csr_word(r_mon, r_ie);
`else
  logic w_unused;
  assign w_unused  = &{1'b0, wb_adr_i, wb_dat_i[15:8], wb_sel_i[1]};
  assign w_csr_sel = 1'b1;
  assign w_rd_data = csr_word(r_mon, r_ie);
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack   <= 1'b0;
      r_dat   <= 16'h0000;
      r_mon   <= 1'b0;
      r_ie    <= 1'b0;
      r_state <= ST_IDLE;
    end else begin
      r_ack   <= wb_cyc_i & wb_stb_i & ~r_ack;
      r_state <= w_state_next;
      if (w_acc) begin
        r_dat <= w_rd_data;
      end
      // A tick beats a same-cycle clearing write.
      if (w_tick_ev) begin
        r_mon <= 1'b1;
      end else if (w_csr_wr && !wb_dat_i[CSR_MON_BIT]) begin
        r_mon <= 1'b0;
      end
      if (w_csr_wr) begin
        r_ie <= wb_dat_i[CSR_IE_BIT];
      end
    end
  end

  // DONE holds irq low for one cycle so the arbiter cannot double-acknowledge.
  always_comb begin
    w_state_next = r_state;
    w_irq        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick_ev && r_ie) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        w_irq = 1'b1;
        if (iack_i) begin
          w_state_next = ST_DONE;
        end else if (w_csr_wr && !wb_dat_i[CSR_IE_BIT]) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = w_irq;
  assign ivec_o   = VECTOR;

endmodule
